// File: rtl/edit_mem_buf_manager.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | edit_mem_buf_manager                                                        |
// | Free-list manager for edit-memory buffer pointers: self-initialising FIFO, |
// | one alloc and one release per cycle.                                        |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module edit_mem_buf_manager #(
  parameter int BPTR_NBITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  buf_req,
  output logic                  buf_gnt,
  output logic [BPTR_NBITS-1:0] buf_gnt_ptr,
  input  logic                  em_rel_buf_valid,
  input  logic [BPTR_NBITS-1:0] em_rel_buf_ptr,
  output logic                  init_done,
  output logic                  buf_avail,
  output logic [BPTR_NBITS:0]   free_cnt,
  output logic                  rel_err
);

  localparam int                  DEPTH    = 2 ** BPTR_NBITS;
  localparam int                  IW       = BPTR_NBITS + 1;
  localparam logic [BPTR_NBITS:0] FULL_CNT = {1'b1, {BPTR_NBITS{1'b0}}};
  localparam logic [BPTR_NBITS-1:0] LAST_PTR = {BPTR_NBITS{1'b1}};

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]            state;
  logic [0:0]            state_nxt;
  logic [BPTR_NBITS-1:0] init_cnt;
  logic [BPTR_NBITS:0]   rd_idx;
  logic [BPTR_NBITS:0]   wr_idx;
  logic [BPTR_NBITS:0]   rd_idx_nxt;
  logic [BPTR_NBITS:0]   wr_idx_nxt;
  logic [BPTR_NBITS-1:0] fifo_mem [DEPTH];

  logic                  list_full;
  logic                  pop;
  logic                  push_init;
  logic                  push_rel;
  logic                  rel_drop;
  logic                  wr_en;
  logic [BPTR_NBITS-1:0] wr_addr;
  logic [BPTR_NBITS-1:0] wr_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT: if (init_cnt == LAST_PTR) state_nxt = ST_RUN;
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = ST_INIT;
    endcase
  end

  // INIT and release share the single FIFO write port; they never coincide.
  always_comb begin
    init_done = (state == ST_RUN);
    buf_avail = init_done && (free_cnt != '0);
    list_full = (free_cnt == FULL_CNT);
    pop       = init_done && buf_req && buf_avail;
    push_init = (state == ST_INIT);
    push_rel  = init_done && em_rel_buf_valid && !list_full;
    rel_drop  = em_rel_buf_valid && !push_rel;
    wr_en     = push_init || push_rel;
    wr_addr   = push_init ? init_cnt : wr_idx[BPTR_NBITS-1:0];
    wr_data   = push_init ? init_cnt : em_rel_buf_ptr;
  end

  assign rd_idx_nxt = rd_idx + IW'(pop);
  assign wr_idx_nxt = wr_idx + IW'(wr_en);

  always_ff @(posedge clk) begin
    if (rst) begin
      init_cnt    <= '0;
      rd_idx      <= '0;
      wr_idx      <= '0;
      free_cnt    <= '0;
      buf_gnt     <= 1'b0;
      buf_gnt_ptr <= '0;
      rel_err     <= 1'b0;
    end else begin
      if (push_init) init_cnt <= init_cnt + BPTR_NBITS'(1);
      rd_idx   <= rd_idx_nxt;
      wr_idx   <= wr_idx_nxt;
      free_cnt <= wr_idx_nxt - rd_idx_nxt;
      buf_gnt  <= pop;
      if (pop) buf_gnt_ptr <= fifo_mem[rd_idx[BPTR_NBITS-1:0]];
      rel_err  <= rel_drop;
    end
  end

  // Contents need no reset: INIT rewrites every entry before any read.
  always_ff @(posedge clk) begin
    if (wr_en) fifo_mem[wr_addr] <= wr_data;
  end

endmodule
`default_nettype wire
